// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan driver and its decoder.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int CODE_W     = 4;
    localparam int GUARD_W    = 8;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [6:0]        seg_t;

    localparam code_t CODE_DASH  = 4'hA;
    localparam code_t CODE_BLANK = 4'hF;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    // Why the current slot is (or is not) dark.
    typedef enum logic [1:0] {
        DISP_LIT   = 2'd0,
        DISP_GUARD = 2'd1,
        DISP_BLINK = 2'd2
    } disp_mode_t;

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the timekeeping logic (master) and the display scanner (slave).
interface seg_scan_if;
    import seg_scan_pkg::*;

    logic                         scan_tick;
    logic                         blink_tick;
    logic [CODE_W*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]        dp_mask;
    logic [NUM_DIGITS-1:0]        blink_mask;
    logic [NUM_DIGITS-1:0]        select_light;
    logic [7:0]                   display_char;

    modport master (
        output scan_tick, blink_tick, digits, dp_mask, blink_mask,
        input  select_light, display_char
    );

    modport slave (
        input  scan_tick, blink_tick, digits, dp_mask, blink_mask,
        output select_light, display_char
    );

endinterface

// File: rtl/seg_scan_bcd_to_seg.sv
// Combinational digit-code to seven-segment decoder; codes B..F render blank.
module bcd_to_seg
    import seg_scan_pkg::*;
(
    input  code_t code,
    output seg_t  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:       seg = SEG_0;
            4'h1:       seg = SEG_1;
            4'h2:       seg = SEG_2;
            4'h3:       seg = SEG_3;
            4'h4:       seg = SEG_4;
            4'h5:       seg = SEG_5;
            4'h6:       seg = SEG_6;
            4'h7:       seg = SEG_7;
            4'h8:       seg = SEG_8;
            4'h9:       seg = SEG_9;
            CODE_DASH:  seg = SEG_DASH;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver with blink mask and anti-ghost guard.
// Digit data is captured once per frame so a whole scan shows one coherent value.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int GUARD_CYCLES = 4
)(
    input  logic      CP,
    input  logic      _CR,
    seg_scan_if.slave bus
);

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0]             idx_reg, idx_next;
    logic [GUARD_W-1:0]           guard_reg, guard_next;
    logic                         phase_reg, phase_next;
    logic [CODE_W*NUM_DIGITS-1:0] digits_q_reg, digits_q_next;
    logic [NUM_DIGITS-1:0]        dp_q_reg, dp_q_next;
    logic [NUM_DIGITS-1:0]        blink_q_reg, blink_q_next;
    logic [NUM_DIGITS-1:0]        select_reg, select_next;
    logic [7:0]                   char_reg, char_next;

    code_t                 digit_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] select_lit;
    code_t                 cur_code;
    seg_t                  cur_seg;
    logic                  frame_end;
    disp_mode_t            mode;

    // Per-digit views of the snapshot and the one-hot enable for the current slot.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_code[gi] = digits_q_reg[CODE_W*gi +: CODE_W];
            assign select_lit[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign cur_code  = digit_code[idx_reg];
    assign frame_end = bus.scan_tick && (idx_reg == LAST_IDX);

    bcd_to_seg u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // Scan index, guard countdown, blink phase and frame snapshot.
    always_comb begin
        idx_next      = idx_reg;
        guard_next    = guard_reg;
        phase_next    = phase_reg;
        digits_q_next = digits_q_reg;
        dp_q_next     = dp_q_reg;
        blink_q_next  = blink_q_reg;

        if (bus.scan_tick) begin
            idx_next   = idx_reg + 1'b1;
            guard_next = GUARD_INIT;
        end else if (guard_reg != '0) begin
            guard_next = guard_reg - 1'b1;
        end

        if (bus.blink_tick) begin
            phase_next = ~phase_reg;
        end

        if (frame_end) begin
            digits_q_next = bus.digits;
            dp_q_next     = bus.dp_mask;
            blink_q_next  = bus.blink_mask;
        end
    end

    // Output decision uses pre-edge state, so a new digit only shows after the guard drains.
    always_comb begin
        mode = DISP_LIT;
        if (guard_reg != '0) begin
            mode = DISP_GUARD;
        end else if (phase_reg && blink_q_reg[idx_reg]) begin
            mode = DISP_BLINK;
        end
    end

    always_comb begin
        select_next = '0;
        char_next   = '0;
        case (mode)
            DISP_LIT: begin
                select_next = select_lit;
                char_next   = {dp_q_reg[idx_reg], cur_seg};
            end
            default: begin
                select_next = '0;
                char_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            idx_reg      <= '0;
            guard_reg    <= '0;
            phase_reg    <= 1'b0;
            digits_q_reg <= '0;
            dp_q_reg     <= '0;
            blink_q_reg  <= '0;
            select_reg   <= '0;
            char_reg     <= '0;
        end else begin
            idx_reg      <= idx_next;
            guard_reg    <= guard_next;
            phase_reg    <= phase_next;
            digits_q_reg <= digits_q_next;
            dp_q_reg     <= dp_q_next;
            blink_q_reg  <= blink_q_next;
            select_reg   <= select_next;
            char_reg     <= char_next;
        end
    end

    assign bus.select_light = select_reg;
    assign bus.display_char = char_reg;

endmodule
